// File: rtl/fifo_drain_arbiter_if.sv
// Handshake bundle between the per-source fifo heads, the drain arbiter and
// the shared downstream consumer.
interface fifo_drain_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]       q_empty;
  logic [N*WIDTH-1:0] q_data;
  logic [N-1:0]       q_r_en;
  logic               m_valid;
  logic               m_ready;
  logic [WIDTH-1:0]   m_data;
  logic [IDW-1:0]     m_id;
  logic               m_last;

  // Arbiter side: reads queue heads, drives read enables and the stream.
  modport master (
    input  q_empty, q_data, m_ready,
    output q_r_en, m_valid, m_data, m_id, m_last
  );

  // Environment side: the fifos plus the downstream consumer.
  modport slave (
    output q_empty, q_data, m_ready,
    input  q_r_en, m_valid, m_data, m_id, m_last
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain arbiter: shares one valid/ready stream among N fifos.
// A grant is held for a whole packet (PACKET=1) or up to MAX_BURST beats
// (PACKET=0). Every grant switch passes through one IDLE cycle.
module fifo_drain_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int PACKET    = 1,
  parameter int MAX_BURST = 16,
  parameter int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  fifo_drain_arbiter_if.master bus
);

  localparam int             CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_r;
  logic [IDW-1:0] grant_r;
  logic [IDW-1:0] last_grant_r;
  logic [CW-1:0]  beat_cnt_r;

  logic [WIDTH-1:0] head_s;
  logic             head_empty_s;
  logic             valid_s;
  logic             accept_s;
  logic             release_s;
  logic             any_req_s;
  logic [IDW-1:0]   next_grant_s;

  // First non-empty queue strictly after 'last', wrapping modulo N.
  // The request vector is doubled so a plain right shift performs the rotation.
  function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0] last,
                                             input logic [N-1:0]   empty);
    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    int             start;
    int             pick;
    logic           found;
    req2  = {~empty, ~empty};
    start = (int'(last) + 1) % N;
    rot   = N'(req2 >> start);
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        pick  = (start + i) % N;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return IDW'(pick);
  endfunction

  // Select the granted queue's head word and empty flag.
  always_comb begin
    head_s       = {WIDTH{1'b0}};
    head_empty_s = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (grant_r == IDW'(i)) begin
        head_s       = bus.q_data[i*WIDTH +: WIDTH];
        head_empty_s = bus.q_empty[i];
      end else begin
        head_s       = head_s;
        head_empty_s = head_empty_s;
      end
    end
  end

  // Handshake terms and the release decision for the current grant.
  always_comb begin
    valid_s      = (state_r == GRANT) && !head_empty_s;
    accept_s     = valid_s && bus.m_ready;
    any_req_s    = |(~bus.q_empty);
    next_grant_s = rr_pick(last_grant_r, bus.q_empty);
    if (state_r != GRANT) begin
      release_s = 1'b0;
    end else if (PACKET != 0) begin
      // Packet mode never gives up on an empty queue: the packet must finish.
      release_s = accept_s && head_s[WIDTH-1];
    end else begin
      release_s = head_empty_s || (accept_s && (beat_cnt_r == LAST_BEAT));
    end
  end

  // Drive the shared stream and the one-hot read enable of the granted queue.
  always_comb begin
    bus.m_valid = valid_s;
    bus.m_data  = head_s;
    bus.m_id    = grant_r;
    bus.q_r_en  = accept_s ? (ONE_HOT0 << grant_r) : {N{1'b0}};
    if (!valid_s) begin
      bus.m_last = 1'b0;
    end else if (PACKET != 0) begin
      bus.m_last = head_s[WIDTH-1];
    end else begin
      bus.m_last = (beat_cnt_r == LAST_BEAT);
    end
  end

  // Grant state machine: pick a queue in IDLE, hold it in GRANT until release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      grant_r      <= {IDW{1'b0}};
      last_grant_r <= LAST_INIT;
      beat_cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r    <= next_grant_s;
            beat_cnt_r <= {CW{1'b0}};
            state_r    <= GRANT;
          end else begin
            state_r    <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            last_grant_r <= grant_r;
            beat_cnt_r   <= {CW{1'b0}};
            state_r      <= IDLE;
          end else if (accept_s) begin
            beat_cnt_r   <= beat_cnt_r + CW'(1);
          end else begin
            beat_cnt_r   <= beat_cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: a packet-mode instance (dut0) and a
// burst-mode instance (dut1, MAX_BURST=4), each fed by bench-side queues.
module tb_fifo_drain_arbiter;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  fifo_drain_arbiter_if #(.N(4), .WIDTH(8)) if0 ();
  fifo_drain_arbiter_if #(.N(4), .WIDTH(8)) if1 ();

  fifo_drain_arbiter #(.N(4), .WIDTH(8), .PACKET(1), .MAX_BURST(16)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .bus(if0)
  );
  fifo_drain_arbiter #(.N(4), .WIDTH(8), .PACKET(0), .MAX_BURST(4)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .bus(if1)
  );

  // Queue contents: index d*4+i is queue i of instance d.
  logic [7:0] fq [8][$];

  // Reference model: current owner (-1 = none), previous owner, beats granted.
  int   owner [2];
  int   lastg [2];
  int   cnt   [2];
  bit   ready [2];
  bit   rand_push;

  // Last sampled outputs, for hand-written sequence checks.
  logic       act_valid [2];
  logic [1:0] act_id    [2];
  logic [7:0] act_data  [2];
  logic [3:0] act_ren   [2];
  logic       act_last  [2];

  int b_id [$];
  int b_last [$];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit       push;
    bit       rdy;
    bit       valid;
    int       id;
    bit [3:0] ren;
    bit       last;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1;
      lastg[d] = 3;
      cnt[d]   = 0;
    end
  endtask

  task automatic push_pkt(input int idx, input int n, input int tag);
    for (int b = 1; b <= n; b++) begin
      fq[idx].push_back({(b == n), 3'(tag), 4'(b)});
    end
  endtask

  task automatic drive();
    logic [3:0]  e  [2];
    logic [31:0] dt [2];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        e[d][i] = (fq[d*4+i].size() == 0);
        dt[d][i*8 +: 8] = e[d][i] ? 8'h00 : fq[d*4+i][0];
      end
    end
    if0.q_empty = e[0];
    if0.q_data  = dt[0];
    if0.m_ready = ready[0];
    if1.q_empty = e[1];
    if1.q_data  = dt[1];
    if1.m_ready = ready[1];
  endtask

  // Compare one instance against the model, then advance the model one clock.
  task automatic model_step(input int d);
    int         own;
    int         base;
    int         j;
    logic       ev;
    logic [7:0] ed;
    logic       erd;
    logic [3:0] eren;
    logic       elast;
    base = d * 4;
    own  = owner[d];
    if (d == 0) begin
      act_valid[0] = if0.m_valid; act_id[0] = if0.m_id; act_data[0] = if0.m_data;
      act_ren[0] = if0.q_r_en; act_last[0] = if0.m_last;
    end else begin
      act_valid[1] = if1.m_valid; act_id[1] = if1.m_id; act_data[1] = if1.m_data;
      act_ren[1] = if1.q_r_en; act_last[1] = if1.m_last;
    end
    ev = 1'b0; ed = 8'h00; erd = 1'b0; eren = 4'b0000; elast = 1'b0;
    if (own >= 0) begin
      ev    = (fq[base+own].size() != 0);
      ed    = ev ? fq[base+own][0] : 8'h00;
      erd   = ev && ready[d];
      eren  = erd ? (4'b0001 << own) : 4'b0000;
      elast = ev && ((d == 0) ? ed[7] : (cnt[d] == 3));
    end
    check($sformatf("d%0d_m_valid", d), act_valid[d], ev);
    check($sformatf("d%0d_q_r_en", d), act_ren[d], eren);
    if (own >= 0) check($sformatf("d%0d_m_id", d), act_id[d], own);
    if (ev) begin
      check($sformatf("d%0d_m_data", d), act_data[d], ed);
      check($sformatf("d%0d_m_last", d), act_last[d], elast);
    end
    if (d == 1 && act_valid[1] === 1'b1 && ready[1]) begin
      b_id.push_back(int'(act_id[1]));
      b_last.push_back(int'(act_last[1]));
    end
    if (own < 0) begin
      for (int k = 1; k <= 4; k++) begin
        j = (lastg[d] + k) % 4;
        if (owner[d] < 0 && fq[base+j].size() != 0) begin
          owner[d] = j;
          cnt[d]   = 0;
        end
      end
    end else begin
      if (erd) void'(fq[base+own].pop_front());
      if ((d == 0) ? (erd && ed[7]) : (!ev || (erd && cnt[d] == 3))) begin
        lastg[d] = own;
        owner[d] = -1;
      end else if (erd) begin
        cnt[d]++;
      end
    end
  endtask

  // One clock: optional random pushes, drive, compare, advance, clock edge.
  task automatic cycle();
    if (rand_push) begin
      for (int q = 0; q < 8; q++) begin
        if (fq[q].size() < 6 && $urandom_range(3) == 0) begin
          fq[q].push_back({($urandom_range(2) == 0), 7'($urandom_range(127))});
        end
      end
    end
    drive();
    #2;
    model_step(0);
    model_step(1);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    bit       r_bp [7];
    bit       v_bp [7];
    bit [7:0] d_bp [7];
    int       exp_id [12];
    int       exp_last [12];

    // Round-robin table: each queue gets a 2-beat packet, then a second round.
    for (int k = 0; k < 15; k++) tbl[k] = '{push: 1'b0, rdy: 1'b1, valid: 1'b0, id: 0, ren: 4'b0000, last: 1'b0};
    tbl[0].push  = 1'b1;
    tbl[12].push = 1'b1;
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 0, 4'b0001, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 0, 4'b0001, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1, 4'b0010, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1, 4'b0010, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 2, 4'b0100, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2, 4'b0100, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 3, 4'b1000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 3, 4'b1000, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 0, 4'b0001, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 0, 4'b0001, 1'b1};

    rand_push = 1'b0;
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    model_reset();
    drive();

    // Reset state of both instances.
    repeat (2) @(posedge aclk);
    #1;
    check("rst_d0_valid", if0.m_valid, 1'b0);
    check("rst_d0_ren",   if0.q_r_en,  4'b0000);
    check("rst_d0_id",    if0.m_id,    2'd0);
    check("rst_d0_last",  if0.m_last,  1'b0);
    check("rst_d1_valid", if1.m_valid, 1'b0);
    check("rst_d1_ren",   if1.q_r_en,  4'b0000);
    aresetn = 1'b1;

    // Table-driven round robin on the packet instance.
    for (int k = 0; k < 15; k++) begin
      if (tbl[k].push) begin
        for (int i = 0; i < 4; i++) push_pkt(i, 2, k + i);
      end
      ready[0] = tbl[k].rdy;
      cycle();
      check($sformatf("rr%0d_valid", k), act_valid[0], tbl[k].valid);
      check($sformatf("rr%0d_ren", k), act_ren[0], tbl[k].ren);
      if (tbl[k].valid) begin
        check($sformatf("rr%0d_id", k), act_id[0], tbl[k].id);
        check($sformatf("rr%0d_last", k), act_last[0], tbl[k].last);
      end
    end
    repeat (12) cycle();

    // Single packet on queue 2 with backpressure 1,0,0,1 in the middle.
    r_bp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    v_bp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    d_bp = '{8'h00, 8'h21, 8'h22, 8'h22, 8'h22, 8'hA3, 8'h00};
    fq[2].push_back(8'h21); fq[2].push_back(8'h22); fq[2].push_back(8'hA3);
    for (int c = 0; c < 7; c++) begin
      ready[0] = r_bp[c];
      cycle();
      check($sformatf("bp%0d_valid", c), act_valid[0], v_bp[c]);
      check($sformatf("bp%0d_ren", c), act_ren[0], (v_bp[c] && r_bp[c]) ? 4'b0100 : 4'b0000);
      if (v_bp[c]) begin
        check($sformatf("bp%0d_data", c), act_data[0], d_bp[c]);
        check($sformatf("bp%0d_id", c), act_id[0], 2'd2);
      end
    end
    check("bp_last", act_last[0], 1'b0);
    ready[0] = 1'b1;

    // Queue 1 runs dry mid-packet while queue 3 waits with a full packet.
    fq[1].push_back(8'h11);
    cycle();
    fq[7 - 4].push_back(8'h31); fq[3].push_back(8'hB2);
    cycle();
    check("st_beat1", act_data[0], 8'h11);
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("st_stall_valid", act_valid[0], 1'b0);
      check("st_stall_id", act_id[0], 2'd1);
      check("st_stall_ren", act_ren[0], 4'b0000);
    end
    fq[1].push_back(8'h12); fq[1].push_back(8'h93);
    cycle();
    check("st_beat2_id", act_id[0], 2'd1);
    cycle();
    check("st_eop", act_last[0], 1'b1);
    cycle();
    check("st_bubble", act_valid[0], 1'b0);
    cycle();
    check("st_q3_id", act_id[0], 2'd3);
    check("st_q3_valid", act_valid[0], 1'b1);
    repeat (3) cycle();

    // Burst instance: queue 0 with 10 words, queue 1 with 2 words.
    b_id.delete();
    b_last.delete();
    for (int w = 0; w < 10; w++) fq[4].push_back(8'(w));
    fq[5].push_back(8'h50); fq[5].push_back(8'h51);
    repeat (22) cycle();
    exp_id   = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    exp_last = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    check("burst_beats", b_id.size(), 12);
    for (int b = 0; b < 12 && b < b_id.size(); b++) begin
      check($sformatf("burst%0d_id", b), b_id[b], exp_id[b]);
      check($sformatf("burst%0d_last", b), b_last[b], exp_last[b]);
    end

    // Reset asserted during beat 2 of a packet on queue 2.
    fq[2].push_back(8'h21); fq[2].push_back(8'h22); fq[2].push_back(8'hA3);
    cycle();
    cycle();
    drive();
    #2;
    check("pre_rst_valid", if0.m_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("async_rst_valid", if0.m_valid, 1'b0);
    check("async_rst_ren", if0.q_r_en, 4'b0000);
    model_reset();
    @(posedge aclk);
    #1;
    check("in_rst_ren", if0.q_r_en, 4'b0000);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    fq[3].push_back(8'h83);
    cycle();
    check("post_rst_idle", act_valid[0], 1'b0);
    cycle();
    check("post_rst_id", act_id[0], 2'd2);
    check("post_rst_data", act_data[0], 8'h22);
    repeat (6) cycle();

    // Randomized traffic and backpressure on both instances.
    rand_push = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ready[0] = ($urandom_range(3) != 0);
      ready[1] = ($urandom_range(3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Round-robin scheduler that shares one downstream valid/ready stream among N fifo instances.
- It watches each queue's empty flag and head data, grants one queue at a time, and drives that queue's r_en on each accepted beat.
- Grants can be packet-atomic (held until an end-of-packet bit) or burst-limited.
- It sits between the per-source fifo instances and a single shared consumer, e.g. a bus master or a serialiser.

Parameters:
- N, 4, number of queues; 2..16.
- WIDTH, 32, queue data width; in packet mode bit WIDTH-1 is the end-of-packet flag.
- PACKET, 1, 1 = hold the grant until a beat with bit WIDTH-1 set is accepted; 0 = burst mode.
- MAX_BURST, 16, burst mode only: maximum beats per grant; 1..256.
- IDW, $clog2(N), width of m_id; minimum 1.

Ports:
- aclk  input  1  clock; all logic on its rising edge.
- aresetn  input  1  asynchronous active-low reset.
- q_empty  input  N  empty flag of each queue.
- q_data  input  N*WIDTH  head data of each queue; queue i occupies [i*WIDTH +: WIDTH]; valid whenever q_empty[i]=0.
- q_r_en  output  N  read enable per queue; at most one bit set in any cycle.
- m_valid  output  1  downstream beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  WIDTH  data of the granted queue's head.
- m_id  output  IDW  index of the granted queue.
- m_last  output  1  last beat of the current grant.

Behaviour:
- Reset (async assert, sync release is the user's concern):
  - state=IDLE, grant=0, last_grant=N-1, beat_cnt=0.
  - Outputs: m_valid=0, q_r_en=0, m_id=0, m_last=0.
  - Reset asserted mid-packet abandons the grant immediately; no q_r_en pulse occurs afterwards.
- State IDLE:
  - m_valid=0 and q_r_en=0.
  - If any q_empty bit is 0: grant <= first non-empty index searching last_grant+1, last_grant+2, ... with wrap modulo N; beat_cnt <= 0; state <= GRANT.
  - Arbitration latency: 1 cycle from a queue going non-empty (while idle) to m_valid.
- State GRANT:
  - m_valid = !q_empty[grant]. m_data = q_data slice[grant]. m_id = grant.
  - q_r_en[grant] = m_valid & m_ready; all other q_r_en bits are 0.
  - A beat is accepted when m_valid & m_ready.
  - m_last in packet mode = m_data[WIDTH-1].
  - m_last in burst mode = (beat_cnt == MAX_BURST-1), or that queue's q_empty will be observed next; only the beat_cnt term is required.
  - beat_cnt is MAX_BURST-width saturating-free; it increments on each accepted beat.
- Release (on the clock edge):
  - PACKET=1: an accepted beat with m_data[WIDTH-1]=1 releases the grant.
  - PACKET=1: if the granted queue goes empty mid-packet, keep the grant and stall with m_valid=0; other queues stay blocked.
  - PACKET=0: an accepted beat with beat_cnt==MAX_BURST-1 releases the grant.
  - PACKET=0: q_empty[grant]=1 while in GRANT releases the grant without a transfer.
  - On release: last_grant <= grant; state <= IDLE. No back-to-back grant without an IDLE cycle, so there is 1 bubble per grant switch.
- Data/valid stability:
  - While m_valid=1 and m_ready=0, m_data and m_id must hold. This is guaranteed because fifo head data is stable while its r_en is low.
  - Within one cycle, m_valid may drop only when the granted queue is empty.
- Round-robin fairness: with all queues continuously non-empty, grants rotate 0,1,...,N-1,0 starting from queue 0 after reset.
- Head advance: the fifo presents the next word the cycle after q_r_en. The arbiter needs no lookahead because q_data and q_empty are re-sampled combinationally every cycle.
- No combinational path from m_ready to m_valid. The path from m_ready to q_r_en is permitted.

Test Plan:
- Single packet: queue 2 loaded with 3 beats, EOP on beat 3, m_ready=1 → m_valid rises 1 cycle after q_empty[2] falls; m_id=2 for 3 cycles; q_r_en[2] pulses 3 cycles; m_last on beat 3; then IDLE.
- Round-robin: all 4 queues hold one 2-beat packet, m_ready=1 → m_id sequence 0,0,1,1,2,2,3,3 with one idle cycle between packets; a second round restarts at 0.
- Backpressure: m_ready toggles 1,0,0,1 during a packet → m_data and m_id stable while stalled; q_r_en asserted only in cycles with m_ready=1.
- Mid-packet starvation: queue 1 empties after beat 1 of 3 while queue 3 is full → m_valid=0 and m_id stays 1; queue 3 is not granted until queue 1 refills and delivers its EOP.
- Burst mode (PACKET=0, MAX_BURST=4): queue 0 holds 10 words, queue 1 holds 2 → grants 0×4, 1×2 (released by empty), 0×4, 0×2; m_last on beats 4 and 8 of queue 0.
- Reset mid-grant: aresetn pulsed low during beat 2 of a packet → q_r_en and m_valid go 0 asynchronously; after release the first grant goes to the lowest non-empty index.
